// File: rtl/ni_req_arbiter.sv
// ni_req_arbiter
//   Shares the NI initiator's single output flit channel between the write-request
//   packetizer (AW+W) and the read-request packetizer (AR). Arbitration is
//   round-robin and packet-atomic. Each channel also has an outstanding-transaction
//   limit, and the response path decrements those counts.
//
// Handshake: a source flit moves across the boundary in the cycle where its ready
//   is high. Ready is high only when the granted channel presents valid and the
//   output buffer is not stalled. That same condition is valid_out, the write
//   strobe into the output buffer. Ready is never high without valid.
//
// Ports:
//   clk, rst               NoC clock; synchronous active-high reset
//   wr_flit/valid/tail     write packet stream in;  wr_ready out
//   rd_flit/valid/tail     read packet stream in;   rd_ready out
//   flit_out, valid_out    flit and write strobe to the output buffer
//   stall_in               output buffer full
//   decr_wr, decr_rd       one-cycle pulses: one response completed
//   wr_outs, rd_outs       outstanding transaction counts
//   outs_busy              any transaction outstanding
//   cnt_err                sticky: decrement seen while a count was zero
//   dbg_state, dbg_pref    FSM state (0 idle, 1 write, 2 read) and RR preference (0 write)
module ni_req_arbiter #(
  parameter int FLIT_WIDTH  = 80,
  parameter int MAX_OUTS_WR = 4,  // 1 .. 2**CNT_WD-1
  parameter int MAX_OUTS_RD = 4,  // 1 .. 2**CNT_WD-1
  parameter int CNT_WD      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] wr_flit,
  input  logic                  wr_valid,
  input  logic                  wr_tail,
  output logic                  wr_ready,
  input  logic [FLIT_WIDTH-1:0] rd_flit,
  input  logic                  rd_valid,
  input  logic                  rd_tail,
  output logic                  rd_ready,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  valid_out,
  input  logic                  stall_in,
  input  logic                  decr_wr,
  input  logic                  decr_rd,
  output logic [CNT_WD-1:0]     wr_outs,
  output logic [CNT_WD-1:0]     rd_outs,
  output logic                  outs_busy,
  output logic                  cnt_err,
  output logic [1:0]            dbg_state,
  output logic                  dbg_pref
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_PKT = 2'd1,
    RD_PKT = 2'd2
  } state_t;

  localparam logic PREF_WR = 1'b0;
  localparam logic PREF_RD = 1'b1;

  localparam logic [CNT_WD-1:0] LIM_WR = CNT_WD'(MAX_OUTS_WR);
  localparam logic [CNT_WD-1:0] LIM_RD = CNT_WD'(MAX_OUTS_RD);
  localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);

  state_t state, state_nxt;
  logic   pref, pref_nxt;
  logic   wr_elig, rd_elig;
  logic   wr_inc, rd_inc;

  // The limit is checked only in IDLE. Once a packet is granted it runs to its tail.
  assign wr_elig = wr_valid && (wr_outs < LIM_WR);
  assign rd_elig = rd_valid && (rd_outs < LIM_RD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pref  <= PREF_WR;
    end else begin
      state <= state_nxt;
      pref  <= pref_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pref_nxt  = pref;
    flit_out  = '0;
    valid_out = 1'b0;
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;
    wr_inc    = 1'b0;
    rd_inc    = 1'b0;
    case (state)
      IDLE: begin
        // No transfer here. Each packet pays a one-cycle arbitration bubble.
        if (wr_elig && (!rd_elig || pref == PREF_WR)) begin
          state_nxt = WR_PKT;
        end else if (rd_elig) begin
          state_nxt = RD_PKT;
        end
      end
      WR_PKT: begin
        flit_out  = wr_flit;
        valid_out = wr_valid && !stall_in;
        wr_ready  = valid_out;
        // The preference flips only on a completed tail, never while stalled.
        if (valid_out && wr_tail) begin
          state_nxt = IDLE;
          pref_nxt  = PREF_RD;
          wr_inc    = 1'b1;
        end
      end
      RD_PKT: begin
        flit_out  = rd_flit;
        valid_out = rd_valid && !stall_in;
        rd_ready  = valid_out;
        if (valid_out && rd_tail) begin
          state_nxt = IDLE;
          pref_nxt  = PREF_WR;
          rd_inc    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outstanding counters. When an increment and a decrement arrive together they
  // cancel, even at zero. That case is not an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_outs <= '0;
      rd_outs <= '0;
      cnt_err <= 1'b0;
    end else begin
      case ({wr_inc, decr_wr})
        2'b10: wr_outs <= wr_outs + CNT_ONE;
        2'b01: begin
          if (wr_outs == '0) cnt_err <= 1'b1;
          else               wr_outs <= wr_outs - CNT_ONE;
        end
        default: ;
      endcase
      case ({rd_inc, decr_rd})
        2'b10: rd_outs <= rd_outs + CNT_ONE;
        2'b01: begin
          if (rd_outs == '0) cnt_err <= 1'b1;
          else               rd_outs <= rd_outs - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign outs_busy = (wr_outs != '0) || (rd_outs != '0);
  assign dbg_state = state;
  assign dbg_pref  = pref;

endmodule

// File: tb/tb_ni_req_arbiter.sv
// tb_ni_req_arbiter
//   Directed bench for ni_req_arbiter. Two source queues stand in for the
//   packetizers. Expected output flits go into exp_q in the order the arbitration
//   should grant them. Every transferred flit is popped from exp_q and compared.
module tb_ni_req_arbiter;
  localparam int FW = 80;
  localparam int CW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [FW-1:0] wr_flit, rd_flit, flit_out;
  logic          wr_valid, wr_tail, wr_ready;
  logic          rd_valid, rd_tail, rd_ready;
  logic          valid_out, stall_in, decr_wr, decr_rd;
  logic [CW-1:0] wr_outs, rd_outs;
  logic          outs_busy, cnt_err;
  logic [1:0]    dbg_state;
  logic          dbg_pref;

  ni_req_arbiter #(
    .FLIT_WIDTH(FW), .MAX_OUTS_WR(4), .MAX_OUTS_RD(4), .CNT_WD(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_flit(wr_flit), .wr_valid(wr_valid), .wr_tail(wr_tail), .wr_ready(wr_ready),
    .rd_flit(rd_flit), .rd_valid(rd_valid), .rd_tail(rd_tail), .rd_ready(rd_ready),
    .flit_out(flit_out), .valid_out(valid_out), .stall_in(stall_in),
    .decr_wr(decr_wr), .decr_rd(decr_rd),
    .wr_outs(wr_outs), .rd_outs(rd_outs), .outs_busy(outs_busy), .cnt_err(cnt_err),
    .dbg_state(dbg_state), .dbg_pref(dbg_pref)
  );

  // ---------------- scoreboard state ----------------
  logic [FW-1:0] exp_q[$];
  logic [FW:0]   wr_src_q[$];  // {tail, flit}
  logic [FW:0]   rd_src_q[$];
  logic [FW-1:0] last_flit;
  logic [FW-1:0] held_flit;
  int total = 0;
  int bad   = 0;
  int used;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_pkt(input bit is_rd, input int id, input int n, input int n_exp);
    logic [FW-1:0] f;
    for (int i = 0; i < n; i++) begin
      f = {32'($urandom), 16'hA5A5, 8'(is_rd), 8'(id), 16'(i)};
      if (is_rd) rd_src_q.push_back({(i == n - 1), f});
      else       wr_src_q.push_back({(i == n - 1), f});
      if (i < n_exp) exp_q.push_back(f);
      last_flit = f;
    end
  endtask

  task automatic drive();
    logic [FW:0] h;
    if (wr_src_q.size() != 0) begin
      h = wr_src_q[0];
      wr_valid = 1'b1; wr_tail = h[FW]; wr_flit = h[FW-1:0];
    end else begin
      wr_valid = 1'b0; wr_tail = 1'b0; wr_flit = '0;
    end
    if (rd_src_q.size() != 0) begin
      h = rd_src_q[0];
      rd_valid = 1'b1; rd_tail = h[FW]; rd_flit = h[FW-1:0];
    end else begin
      rd_valid = 1'b0; rd_tail = 1'b0; rd_flit = '0;
    end
  endtask

  // One cycle: present the source heads after the edge, then check at the falling edge.
  task automatic step();
    logic [FW-1:0] e;
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check("rdy_vs_valid", wr_ready | rd_ready, valid_out);
    if (valid_out) begin
      check("exp_avail", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("flit_order", flit_out, e);
      end
    end else if (dbg_state == 2'd0) begin
      check("idle_flit_zero", flit_out, '0);
    end
    if (wr_ready && wr_src_q.size() != 0) void'(wr_src_q.pop_front());
    if (rd_ready && rd_src_q.size() != 0) void'(rd_src_q.pop_front());
  endtask

  task automatic pulse_decr(input bit w, input bit r);
    decr_wr = w;
    decr_rd = r;
    step();
    decr_wr = 1'b0;
    decr_rd = 1'b0;
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; stall_in = 1'b0; decr_wr = 1'b0; decr_rd = 1'b0;
    wr_flit = '0; wr_valid = 1'b0; wr_tail = 1'b0;
    rd_flit = '0; rd_valid = 1'b0; rd_tail = 1'b0;

    // reset state
    step();
    step();
    check("rst_state", dbg_state, 2'd0);
    check("rst_pref", dbg_pref, 1'b0);
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_ready", rd_ready, 1'b0);
    check("rst_wr_outs", wr_outs, 0);
    check("rst_rd_outs", rd_outs, 0);
    check("rst_busy", outs_busy, 1'b0);
    check("rst_cnt_err", cnt_err, 1'b0);
    rst = 1'b0;

    // alternating 3-flit packets, no stall
    add_pkt(0, 1, 3, 3);
    add_pkt(1, 1, 3, 3);
    add_pkt(0, 2, 3, 3);
    add_pkt(1, 2, 3, 3);
    used = 0;
    while (exp_q.size() > 6 && used < 40) begin
      step();
      used++;
    end
    check("alt_first_two_cycles", used, 8);
    step();
    check("alt_bubble", valid_out, 1'b0);
    check("alt_wr_outs1", wr_outs, 1);
    check("alt_rd_outs1", rd_outs, 1);
    check("alt_busy", outs_busy, 1'b1);
    drain(40, used);
    step();
    check("alt_wr_outs2", wr_outs, 2);
    check("alt_rd_outs2", rd_outs, 2);
    pulse_decr(1, 1);
    pulse_decr(1, 1);
    check("dec_wr_zero", wr_outs, 0);
    check("dec_rd_zero", rd_outs, 0);
    check("dec_not_busy", outs_busy, 1'b0);

    // 4-flit write stalled for flits 2..4 while a read waits
    add_pkt(0, 3, 4, 4);
    add_pkt(1, 3, 1, 1);
    step();
    check("stall_idle", valid_out, 1'b0);
    step();
    check("stall_first_flit", wr_ready, 1'b1);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_wr_ready", wr_ready, 1'b0);
      check("stall_rd_ready", rd_ready, 1'b0);
      check("stall_hold_grant", dbg_state, 2'd1);
    end
    stall_in = 1'b0;
    drain(20, used);
    pulse_decr(1, 1);
    check("stall_wr_back0", wr_outs, 0);

    // write limit: four writes fill the window, the fifth waits
    for (int i = 0; i < 4; i++) add_pkt(0, 16 + i, 1, 1);
    add_pkt(0, 20, 1, 0);
    held_flit = last_flit;
    drain(40, used);
    step();
    check("lim_wr_outs4", wr_outs, 4);
    check("lim_wr_held", wr_ready, 1'b0);
    add_pkt(1, 21, 1, 1);
    add_pkt(1, 22, 1, 1);
    drain(20, used);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lim_wr_still_held", wr_ready, 1'b0);
    end
    check("lim_rd_outs", rd_outs, 2);
    exp_q.push_back(held_flit);
    pulse_decr(1, 0);
    check("lim_after_decr", wr_outs, 3);
    step();
    check("lim_granted", wr_ready, 1'b1);
    step();
    check("lim_wr_outs_back4", wr_outs, 4);

    // tail and decrement in the same cycle
    pulse_decr(1, 0);
    pulse_decr(1, 0);
    check("both_pre", wr_outs, 2);
    add_pkt(0, 30, 1, 1);
    step();
    step();
    check("both_xfer", wr_ready, 1'b1);
    decr_wr = 1'b1;
    step();
    decr_wr = 1'b0;
    check("both_wr_outs", wr_outs, 2);
    check("both_no_err", cnt_err, 1'b0);

    // decrement at zero sets the sticky error
    pulse_decr(0, 1);
    pulse_decr(0, 1);
    check("uf_rd_zero", rd_outs, 0);
    check("uf_err_clear", cnt_err, 1'b0);
    pulse_decr(0, 1);
    check("uf_rd_stays0", rd_outs, 0);
    check("uf_err_set", cnt_err, 1'b1);
    step();
    step();
    check("uf_err_sticky", cnt_err, 1'b1);

    // reset during a 5-flit read packet, after two flits
    add_pkt(1, 40, 5, 2);
    drain(20, used);
    rst = 1'b1;
    rd_src_q.delete();
    wr_src_q.delete();
    step();
    rst = 1'b0;
    check("mid_rst_state", dbg_state, 2'd0);
    check("mid_rst_valid", valid_out, 1'b0);
    check("mid_rst_wr_outs", wr_outs, 0);
    check("mid_rst_rd_outs", rd_outs, 0);
    check("mid_rst_busy", outs_busy, 1'b0);
    check("mid_rst_pref", dbg_pref, 1'b0);
    check("mid_rst_err", cnt_err, 1'b0);
    add_pkt(0, 41, 2, 2);
    add_pkt(1, 42, 1, 1);
    drain(20, used);
    step();
    check("post_rst_wr_outs", wr_outs, 1);
    check("post_rst_rd_outs", rd_outs, 1);

    // increment and decrement together at zero
    pulse_decr(1, 1);
    add_pkt(1, 50, 1, 1);
    step();
    step();
    check("zero_both_xfer", rd_ready, 1'b1);
    decr_rd = 1'b1;
    step();
    decr_rd = 1'b0;
    check("zero_both_cnt", rd_outs, 0);
    check("zero_both_no_err", cnt_err, 1'b0);

    // read-only traffic: every packet granted, one per two cycles
    add_pkt(1, 60, 1, 1);
    add_pkt(1, 61, 1, 1);
    add_pkt(1, 62, 1, 1);
    drain(30, used);
    check("rd_only_cycles", used, 6);
    step();
    check("rd_only_outs", rd_outs, 3);
    check("rd_only_pref", dbg_pref, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
